// File: rtl/audio_mixer.sv
// Multi-channel audio mixer: a per-channel gain stage, left/right routing, then a master gain with output saturation.
// Optional peak meters are enabled by defining AUDIO_MIXER_PEAK_EN.
module audio_mixer #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned VOL_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_tick,
  input  logic [CHANNELS*SAMPLE_W-1:0] ch_sample,
  input  logic [CHANNELS*VOL_W-1:0]    ch_volume,
  input  logic [CHANNELS-1:0]          ch_enable,
  input  logic [CHANNELS-1:0]          ch_is_mono,
  input  logic [CHANNELS-1:0]          ch_is_right,
  input  logic [VOL_W-1:0]             master_volume,
  input  logic                         peak_clear,
  output logic [SAMPLE_W-1:0]          out_left,
  output logic [SAMPLE_W-1:0]          out_right,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         clip_left,
  output logic                         clip_right,
  output logic [SAMPLE_W-1:0]          peak_left,
  output logic [SAMPLE_W-1:0]          peak_right
);

  localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ACC_W  = SAMPLE_W + VOL_W + $clog2(CHANNELS) + 1;
  localparam int unsigned TERM_W = SAMPLE_W + VOL_W + 1;
  localparam int unsigned PROD_W = ACC_W + VOL_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] SCALE  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic signed [PROD_W-1:0]   SAT_MAX = PROD_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0]   SAT_MIN = PROD_W'(-(64'sd1 <<< (SAMPLE_W - 1)));
  localparam logic signed [SAMPLE_W-1:0] OUT_MAX = SAMPLE_W'(SAT_MAX);
  localparam logic signed [SAMPLE_W-1:0] OUT_MIN = SAMPLE_W'(SAT_MIN);

  logic [1:0]                   state, state_nxt;
  logic [IDX_W-1:0]             idx;
  logic signed [ACC_W-1:0]      acc_l, acc_r;
  logic [CHANNELS*SAMPLE_W-1:0] snap_sample;
  logic [CHANNELS*VOL_W-1:0]    snap_volume;
  logic [CHANNELS-1:0]          snap_en, snap_mono, snap_right;
  logic [VOL_W-1:0]             snap_master;

  logic signed [SAMPLE_W-1:0] cur_sample;
  logic [VOL_W-1:0]           cur_vol;
  logic signed [TERM_W-1:0]   term;
  logic                       add_l, add_r, last_ch;
  logic signed [PROD_W-1:0]   scaled_l, scaled_r;
  logic signed [SAMPLE_W-1:0] sat_l, sat_r;
  logic                       clip_l_c, clip_r_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = ACCUM;
      ACCUM:   if (last_ch) state_nxt = SCALE;
      SCALE:   state_nxt = OUTPUT;
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current channel gain term and routing, taken from the frame snapshot
  assign cur_sample = snap_sample[int'(idx)*SAMPLE_W +: SAMPLE_W];
  assign cur_vol    = snap_volume[int'(idx)*VOL_W +: VOL_W];
  assign term       = (TERM_W'(cur_sample) * TERM_W'($signed({1'b0, cur_vol}))) >>> (VOL_W - 1);
  assign add_l      = snap_en[idx] && (snap_mono[idx] || !snap_right[idx]);
  assign add_r      = snap_en[idx] && (snap_mono[idx] || snap_right[idx]);
  assign last_ch    = (idx == IDX_W'(CHANNELS - 1));

  // Master gain and saturation
  always_comb begin
    scaled_l = (PROD_W'(acc_l) * PROD_W'($signed({1'b0, snap_master}))) >>> (VOL_W - 1);
    scaled_r = (PROD_W'(acc_r) * PROD_W'($signed({1'b0, snap_master}))) >>> (VOL_W - 1);
    clip_l_c = (scaled_l > SAT_MAX) || (scaled_l < SAT_MIN);
    clip_r_c = (scaled_r > SAT_MAX) || (scaled_r < SAT_MIN);
    sat_l    = (scaled_l > SAT_MAX) ? OUT_MAX : (scaled_l < SAT_MIN) ? OUT_MIN : SAMPLE_W'(scaled_l);
    sat_r    = (scaled_r > SAT_MAX) ? OUT_MAX : (scaled_r < SAT_MIN) ? OUT_MIN : SAMPLE_W'(scaled_r);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      snap_sample <= '0;
      snap_volume <= '0;
      snap_en     <= '0;
      snap_mono   <= '0;
      snap_right  <= '0;
      snap_master <= '0;
      out_left    <= '0;
      out_right   <= '0;
      clip_left   <= 1'b0;
      clip_right  <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      busy      <= (state_nxt != IDLE);
      overrun   <= sample_tick && (state != IDLE);
      case (state)
        IDLE: if (sample_tick) begin
          snap_sample <= ch_sample;
          snap_volume <= ch_volume;
          snap_en     <= ch_enable;
          snap_mono   <= ch_is_mono;
          snap_right  <= ch_is_right;
          snap_master <= master_volume;
          acc_l       <= '0;
          acc_r       <= '0;
          idx         <= '0;
        end
        ACCUM: begin
          if (add_l) acc_l <= acc_l + ACC_W'(term);
          if (add_r) acc_r <= acc_r + ACC_W'(term);
          if (!last_ch) idx <= idx + IDX_W'(1);
        end
        SCALE: begin
          out_left   <= sat_l;
          out_right  <= sat_r;
          clip_left  <= clip_l_c;
          clip_right <= clip_r_c;
          out_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AUDIO_MIXER_PEAK_EN
  function automatic logic [SAMPLE_W-1:0] mag(input logic signed [SAMPLE_W-1:0] s);
    if (s == OUT_MIN)   return OUT_MAX;
    else if (s < 0)     return SAMPLE_W'(-s);
    else                return s;
  endfunction

  logic [SAMPLE_W-1:0] mag_l, mag_r;
  assign mag_l = mag(out_left);
  assign mag_r = mag(out_right);

  // Peak meters; a clear coinciding with a new frame loads that frame's magnitude
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (out_valid) begin
      if (peak_clear || mag_l > peak_left)  peak_left  <= mag_l;
      if (peak_clear || mag_r > peak_right) peak_right <= mag_r;
    end else if (peak_clear) begin
      peak_left  <= '0;
      peak_right <= '0;
    end
  end
`else
  logic unused_peak_clear;
  assign unused_peak_clear = peak_clear;
  assign peak_left  = '0;
  assign peak_right = '0;
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Directed, table-driven bench for audio_mixer (CHANNELS=8, SAMPLE_W=16, VOL_W=8).
module tb_audio_mixer;
  localparam int CH = 8;
  localparam int SW = 16;
  localparam int VW = 8;
  localparam int LAT = CH + 2;

  logic            clk = 1'b0;
  logic            rst, sample_tick, peak_clear;
  logic [CH*SW-1:0] ch_sample;
  logic [CH*VW-1:0] ch_volume;
  logic [CH-1:0]   ch_enable, ch_is_mono, ch_is_right;
  logic [VW-1:0]   master_volume;
  logic [SW-1:0]   out_left, out_right, peak_left, peak_right;
  logic            out_valid, busy, overrun, clip_left, clip_right;

  audio_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .VOL_W(VW)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .ch_sample(ch_sample), .ch_volume(ch_volume), .ch_enable(ch_enable),
    .ch_is_mono(ch_is_mono), .ch_is_right(ch_is_right), .master_volume(master_volume),
    .peak_clear(peak_clear), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .clip_left(clip_left), .clip_right(clip_right),
    .peak_left(peak_left), .peak_right(peak_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*SW-1:0] samp;
    logic [CH*VW-1:0] vol;
    logic [CH-1:0]    en, mono, rt;
    logic [VW-1:0]    master;
    int               el, er;
    logic             cl, cr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int c, input int s, input int v,
                        input bit en, input bit mono, input bit rt);
    vecs[k].samp[c*SW +: SW] = SW'(s);
    vecs[k].vol[c*VW +: VW]  = VW'(v);
    vecs[k].en[c]   = en;
    vecs[k].mono[c] = mono;
    vecs[k].rt[c]   = rt;
  endtask

  task automatic set_exp(input int k, input int m, input int el, input int er,
                         input bit cl, input bit cr);
    vecs[k].master = VW'(m);
    vecs[k].el = el;
    vecs[k].er = er;
    vecs[k].cl = cl;
    vecs[k].cr = cr;
  endtask

  task automatic apply(input int k);
    ch_sample     = vecs[k].samp;
    ch_volume     = vecs[k].vol;
    ch_enable     = vecs[k].en;
    ch_is_mono    = vecs[k].mono;
    ch_is_right   = vecs[k].rt;
    master_volume = vecs[k].master;
  endtask

  // Pulse sample_tick for one cycle and wait (bounded) for out_valid; lat = cycles after the tick cycle
  task automatic run_frame(output int lat, output logic busy1);
    lat = -1;
    busy1 = 1'b0;
    sample_tick = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) begin
        sample_tick = 1'b0;
        busy1 = busy;
      end
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  int   lat, nvalid, vcyc;
  logic b1;
  logic signed [SW-1:0] held_l;

  initial begin
    for (int k = 0; k < NV; k++) begin
      vecs[k].samp = '0; vecs[k].vol = '0;
      vecs[k].en = '0; vecs[k].mono = '0; vecs[k].rt = '0;
    end
    set_ch(0, 0, 1000, 128, 1, 1, 0);      set_exp(0, 128, 1000, 1000, 0, 0);
    for (int c = 0; c < CH; c++) set_ch(1, c, 16000, 128, 1, 1, 0);
    set_exp(1, 128, 32767, 32767, 1, 1);
    set_ch(2, 0, -1000, 64, 1, 0, 1);      set_exp(2, 128, 0, -500, 0, 0);
    for (int c = 0; c < CH; c++) set_ch(3, c, -16000, 128, 1, 1, 0);
    set_exp(3, 128, -32768, -32768, 1, 1);
    set_ch(4, 0, 1000, 128, 1, 0, 0);
    set_ch(4, 1, 2000, 128, 1, 0, 1);      set_exp(4, 128, 1000, 2000, 0, 0);
    set_ch(5, 0, -1, 1, 1, 1, 0);          set_exp(5, 128, -1, -1, 0, 0);
    set_ch(6, 0, 3, 255, 1, 1, 0);         set_exp(6, 255, 9, 9, 0, 0);
    set_ch(7, 0, 1000, 128, 0, 1, 0);
    set_ch(7, 1, 500, 128, 1, 1, 0);       set_exp(7, 128, 500, 500, 0, 0);
    set_ch(8, 0, 1000, 128, 1, 1, 0);      set_exp(8, 0, 0, 0, 0, 0);
    set_ch(9, 0, 1000, 128, 1, 1, 0);      set_exp(9, 255, 1992, 1992, 0, 0);

    rst = 1'b1; sample_tick = 1'b0; peak_clear = 1'b0;
    apply(0);
    step(); step(); step();
    chk("reset out_left", out_left, 0);
    chk("reset out_right", out_right, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset clip", {clip_left, clip_right}, 0);
    chk("reset peak", {peak_left, peak_right}, 0);
    rst = 1'b0;
    step();

    for (int k = 0; k < NV; k++) begin
      apply(k);
      run_frame(lat, b1);
      chk($sformatf("v%0d latency", k), lat, LAT);
      chk($sformatf("v%0d busy", k), b1, 1);
      chk($sformatf("v%0d out_left", k), $signed(out_left), vecs[k].el);
      chk($sformatf("v%0d out_right", k), $signed(out_right), vecs[k].er);
      chk($sformatf("v%0d clip_left", k), clip_left, vecs[k].cl);
      chk($sformatf("v%0d clip_right", k), clip_right, vecs[k].cr);
      held_l = out_left;
      step();
      chk($sformatf("v%0d valid one cycle", k), out_valid, 0);
      chk($sformatf("v%0d out_left hold", k), $signed(out_left), held_l);
      chk($sformatf("v%0d idle", k), busy, 0);
    end

    // Second tick mid-frame: overrun pulse, first frame unaffected by new inputs
    apply(0);
    sample_tick = 1'b1;
    nvalid = 0; vcyc = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) sample_tick = 1'b0;
      if (n == 3) begin
        sample_tick = 1'b1;
        apply(9);
      end
      if (n == 4) begin
        chk("overrun pulse", overrun, 1);
        sample_tick = 1'b0;
      end
      if (n == 5) chk("overrun one cycle", overrun, 0);
      if (out_valid) begin
        nvalid++;
        vcyc = n;
        chk("overrun frame out_left", $signed(out_left), 1000);
      end
    end
    chk("overrun single valid", nvalid, 1);
    chk("overrun valid cycle", vcyc, LAT);

    // Reset mid-frame aborts with no output
    apply(0);
    sample_tick = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 1) sample_tick = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort out_left", out_left, 0);
    chk("abort out_right", out_right, 0);
    chk("abort busy", busy, 0);
    nvalid = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (out_valid) nvalid++;
    end
    chk("abort no valid", nvalid, 0);

    // Reset dominates a simultaneous tick
    rst = 1'b1; sample_tick = 1'b1;
    step();
    rst = 1'b0; sample_tick = 1'b0;
    chk("rst over tick busy", busy, 0);
    step();
    chk("rst over tick busy later", busy, 0);

    apply(4);
    run_frame(lat, b1);
    chk("post-reset latency", lat, LAT);
    chk("post-reset out_left", $signed(out_left), 1000);
    chk("post-reset out_right", $signed(out_right), 2000);
    step();

    // Peak meters
    peak_clear = 1'b1;
    step();
    peak_clear = 1'b0;
    apply(0);
    run_frame(lat, b1);
    step();
    vecs[0].samp[SW-1:0] = SW'(-3000);
    apply(0);
    run_frame(lat, b1);
    chk("neg frame out_left", $signed(out_left), -3000);
    step(); step();
`ifdef AUDIO_MIXER_PEAK_EN
    chk("peak_left", peak_left, 3000);
    chk("peak_right", peak_right, 3000);
    peak_clear = 1'b1;
    step();
    peak_clear = 1'b0;
    step();
    chk("peak_left cleared", peak_left, 0);
    chk("peak_right cleared", peak_right, 0);
`else
    chk("peak_left off", peak_left, 0);
    chk("peak_right off", peak_right, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
